// File: rtl/zero_io_pkg.sv
// zero_io_pkg: definitions shared by the Zero multi-channel I/O unit.
//   io_op_t         machine-side command opcodes (in, out, inSize, outFree)
//   ERR_*           values carried on the err pulse
//   RSP_BAD_CHAN    rsp_data returned for an out-of-range channel
//   chan_w()        channel index width, never less than 1 bit
package zero_io_pkg;

  typedef enum logic [1:0] {
    IO_IN      = 2'd0,
    IO_OUT     = 2'd1,
    IO_INSIZE  = 2'd2,
    IO_OUTFREE = 2'd3
  } io_op_t;

  localparam logic ERR_NONE     = 1'b0;
  localparam logic ERR_BAD_CHAN = 1'b1;
  localparam int   RSP_BAD_CHAN = 0;

  // A single channel still needs a 1-bit index field.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/zero_io_channels_if.sv
// zero_io_channels_if: command/response port and external stream bundle.
//   cmd_*         machine command (valid/ready), opcode, channel, out data
//   rsp_*, err    one-cycle result pulse and bad-channel flag
//   ext_in_*      per-channel input streams, channel c at [c*WIDTH +: WIDTH]
//   ext_out_*     per-channel output streams, same packing
// master drives commands and external streams; slave is the I/O unit.
interface zero_io_channels_if #(
  parameter int WIDTH = 12,
  parameter int NCHAN = 2
);
  import zero_io_pkg::*;

  localparam int CW = chan_w(NCHAN);

  logic                   cmd_valid;
  logic                   cmd_ready;
  io_op_t                 cmd_op;
  logic [CW-1:0]          cmd_chan;
  logic [WIDTH-1:0]       cmd_data;
  logic                   rsp_valid;
  logic [WIDTH-1:0]       rsp_data;
  logic                   err;
  logic [NCHAN-1:0]       ext_in_valid;
  logic [NCHAN*WIDTH-1:0] ext_in_data;
  logic [NCHAN-1:0]       ext_in_ready;
  logic [NCHAN-1:0]       ext_out_valid;
  logic [NCHAN*WIDTH-1:0] ext_out_data;
  logic [NCHAN-1:0]       ext_out_ready;

  modport master (
    output cmd_valid, cmd_op, cmd_chan, cmd_data,
    output ext_in_valid, ext_in_data, ext_out_ready,
    input  cmd_ready, rsp_valid, rsp_data, err,
    input  ext_in_ready, ext_out_valid, ext_out_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_chan, cmd_data,
    input  ext_in_valid, ext_in_data, ext_out_ready,
    output cmd_ready, rsp_valid, rsp_data, err,
    output ext_in_ready, ext_out_valid, ext_out_data
  );

endinterface

// File: rtl/zero_io_fifo.sv
// zero_io_fifo: DEPTH-entry synchronous FIFO with a combinational head.
//   clock, reset   rising-edge clock, synchronous active-high reset
//   push/push_data write one entry (ignored while full)
//   pop            drop the head entry (ignored while empty)
//   head           current head entry, meaningful while !empty
//   count          occupancy 0..DEPTH; full/empty decoded from it
module zero_io_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [SW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == SW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/zero_io_channels.sv
// zero_io_channels: NCHAN input and NCHAN output FIFO channels for the Zero
// machine, serving the in / out / inSize / outFree instructions.
//   clock, reset  rising-edge clock, synchronous active-high reset
//   io (slave)    command/response port plus external valid/ready streams
// Responses (in, inSize, outFree, bad channel) appear exactly one cycle after
// acceptance; out produces no response.
module zero_io_channels
  import zero_io_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int NCHAN = 2,
  parameter int DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  zero_io_channels_if.slave io
);
  localparam int              CW      = chan_w(NCHAN);
  localparam int              SW      = $clog2(DEPTH+1);
  localparam logic [CW:0]     NCHAN_C = (CW+1)'(NCHAN);
  localparam logic [SW-1:0]   DEPTH_C = SW'(DEPTH);

  logic [WIDTH-1:0]       w_in_head  [NCHAN];
  logic [SW-1:0]          w_in_count [NCHAN];
  logic [SW-1:0]          w_out_count[NCHAN];
  logic [NCHAN-1:0]       w_in_full, w_in_empty, w_in_pop;
  logic [NCHAN-1:0]       w_out_full, w_out_empty, w_out_push, w_out_pop;
  logic [NCHAN*WIDTH-1:0] w_ext_out_data;

  logic             w_chan_ok;
  logic [CW-1:0]    w_chan;
  logic             w_cmd_ready;
  logic             w_accept;
  logic             w_rsp_valid_next;
  logic [WIDTH-1:0] w_rsp_data_next;
  logic             w_err_next;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_err;

  // Out-of-range channels are steered to channel 0 for lookups only; every
  // FIFO side effect is additionally gated by w_chan_ok.
  assign w_chan_ok = ({1'b0, io.cmd_chan} < NCHAN_C);
  assign w_chan    = w_chan_ok ? io.cmd_chan : '0;
  assign w_accept  = io.cmd_valid && w_cmd_ready;

  // Ready looks only at registered FIFO state: no bypass of a same-cycle
  // external push into an empty input or pop from a full output.
  always_comb begin
    w_cmd_ready = 1'b1;
    if (w_chan_ok) begin
      case (io.cmd_op)
        IO_IN:   w_cmd_ready = !w_in_empty[w_chan];
        IO_OUT:  w_cmd_ready = !w_out_full[w_chan];
        default: w_cmd_ready = 1'b1;
      endcase
    end
  end

  for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
    assign w_in_pop[gi]   = w_accept && w_chan_ok && (io.cmd_op == IO_IN)  && (w_chan == CW'(gi));
    assign w_out_push[gi] = w_accept && w_chan_ok && (io.cmd_op == IO_OUT) && (w_chan == CW'(gi));
    assign w_out_pop[gi]  = io.ext_out_ready[gi] && !w_out_empty[gi];

    zero_io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (io.ext_in_valid[gi]),
      .push_data (io.ext_in_data[gi*WIDTH +: WIDTH]),
      .pop       (w_in_pop[gi]),
      .head      (w_in_head[gi]),
      .count     (w_in_count[gi]),
      .full      (w_in_full[gi]),
      .empty     (w_in_empty[gi])
    );

    zero_io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (w_out_push[gi]),
      .push_data (io.cmd_data),
      .pop       (w_out_pop[gi]),
      .head      (w_ext_out_data[gi*WIDTH +: WIDTH]),
      .count     (w_out_count[gi]),
      .full      (w_out_full[gi]),
      .empty     (w_out_empty[gi])
    );
  end

  assign io.cmd_ready     = w_cmd_ready;
  assign io.ext_in_ready  = ~w_in_full;
  assign io.ext_out_valid = ~w_out_empty;
  assign io.ext_out_data  = w_ext_out_data;

  // rsp_data holds its last value between responses to avoid needless toggling.
  always_comb begin
    w_rsp_valid_next = 1'b0;
    w_rsp_data_next  = r_rsp_data;
    w_err_next       = ERR_NONE;
    if (w_accept) begin
      if (!w_chan_ok) begin
        w_rsp_valid_next = 1'b1;
        w_rsp_data_next  = WIDTH'(RSP_BAD_CHAN);
        w_err_next       = ERR_BAD_CHAN;
      end else begin
        case (io.cmd_op)
          IO_IN: begin
            w_rsp_valid_next = 1'b1;
            w_rsp_data_next  = w_in_head[w_chan];
          end
          IO_INSIZE: begin
            w_rsp_valid_next = 1'b1;
            w_rsp_data_next  = WIDTH'(w_in_count[w_chan]);
          end
          IO_OUTFREE: begin
            w_rsp_valid_next = 1'b1;
            w_rsp_data_next  = WIDTH'(DEPTH_C - w_out_count[w_chan]);
          end
          default: w_rsp_valid_next = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_data  <= w_rsp_data_next;
      r_err       <= w_err_next;
    end
  end

  assign io.rsp_valid = r_rsp_valid;
  assign io.rsp_data  = r_rsp_data;
  assign io.err       = r_err;

endmodule

// File: tb/tb_zero_io_channels.sv
// tb_zero_io_channels: directed scenarios plus randomized traffic for
// zero_io_channels, checked every cycle against a queue-based model.
// Three channels are used so that cmd_chan=3 is a representable bad channel.
module tb_zero_io_channels;
  import zero_io_pkg::*;

  localparam int WIDTH = 12;
  localparam int NCHAN = 3;
  localparam int DEPTH = 8;
  localparam int CW    = chan_w(NCHAN);

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  zero_io_channels_if #(.WIDTH(WIDTH), .NCHAN(NCHAN)) io ();

  zero_io_channels #(.WIDTH(WIDTH), .NCHAN(NCHAN), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .io    (io)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] in_q  [NCHAN][$];
  logic [WIDTH-1:0] out_q [NCHAN][$];
  bit               live = 0;
  bit               exp_rv = 0;
  bit               exp_err = 0;
  bit               exp_rd_known = 0;
  logic [WIDTH-1:0] exp_rd = '0;
  bit               m_in_push  [NCHAN];
  bit               m_out_pop  [NCHAN];

  function automatic bit mdl_ready(input io_op_t op, input int ch);
    if (ch >= NCHAN) return 1'b1;
    case (op)
      IO_IN:   return in_q[ch].size() != 0;
      IO_OUT:  return out_q[ch].size() < DEPTH;
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge clock) begin
    bit     acc;
    int     ch;
    io_op_t op;
    if (reset) begin
      for (int c = 0; c < NCHAN; c++) begin
        in_q[c].delete();
        out_q[c].delete();
      end
      exp_rv = 0; exp_err = 0; exp_rd = '0; exp_rd_known = 1; live = 1;
    end else if (live) begin
      op  = io.cmd_op;
      ch  = int'(io.cmd_chan);
      acc = io.cmd_valid && mdl_ready(op, ch);
      exp_rv = 0; exp_err = 0;
      if (acc) begin
        if (ch >= NCHAN) begin
          exp_rv = 1; exp_err = 1; exp_rd = '0;
        end else begin
          case (op)
            IO_IN:      begin exp_rv = 1; exp_rd = in_q[ch][0]; end
            IO_INSIZE:  begin exp_rv = 1; exp_rd = WIDTH'(in_q[ch].size()); end
            IO_OUTFREE: begin exp_rv = 1; exp_rd = WIDTH'(DEPTH - out_q[ch].size()); end
            default:    exp_rv = 0;
          endcase
        end
      end
      exp_rd_known = exp_rv;
      for (int c = 0; c < NCHAN; c++) begin
        m_in_push[c] = io.ext_in_valid[c] && (in_q[c].size() < DEPTH);
        m_out_pop[c] = io.ext_out_ready[c] && (out_q[c].size() > 0);
      end
      if (acc && ch < NCHAN && op == IO_IN) void'(in_q[ch].pop_front());
      for (int c = 0; c < NCHAN; c++) begin
        if (m_in_push[c]) in_q[c].push_back(io.ext_in_data[c*WIDTH +: WIDTH]);
        if (m_out_pop[c]) void'(out_q[c].pop_front());
      end
      if (acc && ch < NCHAN && op == IO_OUT) out_q[ch].push_back(io.cmd_data);
    end
  end

  // Every-cycle comparison, sampled mid-low-phase after stimulus settles.
  always begin
    @(negedge clock);
    #2;
    if (live) begin
      check("cmd_ready", io.cmd_ready, mdl_ready(io.cmd_op, int'(io.cmd_chan)));
      for (int c = 0; c < NCHAN; c++) begin
        check($sformatf("ext_in_ready[%0d]", c), io.ext_in_ready[c], in_q[c].size() < DEPTH);
        check($sformatf("ext_out_valid[%0d]", c), io.ext_out_valid[c], out_q[c].size() > 0);
        if (out_q[c].size() > 0)
          check($sformatf("ext_out_data[%0d]", c), io.ext_out_data[c*WIDTH +: WIDTH], out_q[c][0]);
      end
      check("rsp_valid", io.rsp_valid, exp_rv);
      check("err", io.err, exp_err);
      if (exp_rd_known) check("rsp_data", io.rsp_data, exp_rd);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic ext_push(input int c, input logic [WIDTH-1:0] v);
    int n = 0;
    @(negedge clock);
    io.ext_in_valid[c] = 1'b1;
    io.ext_in_data[c*WIDTH +: WIDTH] = v;
    #1;
    while (!io.ext_in_ready[c] && n < 50) begin @(negedge clock); #1; n++; end
    @(negedge clock);
    io.ext_in_valid[c] = 1'b0;
  endtask

  task automatic do_cmd(input io_op_t op, input int chan, input logic [WIDTH-1:0] data,
                        input bit chk, input logic [WIDTH-1:0] lit, input string nm);
    int n = 0;
    @(negedge clock);
    io.cmd_valid = 1'b1; io.cmd_op = op; io.cmd_chan = CW'(chan); io.cmd_data = data;
    #1;
    while (!io.cmd_ready && n < 50) begin @(negedge clock); #1; n++; end
    if (!io.cmd_ready) begin
      n_checks++;
      $display("FAIL %s: timeout, cmd_ready stayed 0 expected 1", nm);
      @(negedge clock);
      io.cmd_valid = 1'b0;
      return;
    end
    @(negedge clock);
    io.cmd_valid = 1'b0;
    #3;
    if (chk) begin
      check({nm, "_valid"}, io.rsp_valid, 1);
      check(nm, io.rsp_data, lit);
    end
  endtask

  // ---------------- scenarios ----------------
  logic [WIDTH-1:0] exp_seq[$];
  logic [WIDTH-1:0] nv;
  bit prev_acc, acc_now, push_now;
  int k;

  initial begin
    io.cmd_valid = 0; io.cmd_op = IO_IN; io.cmd_chan = '0; io.cmd_data = '0;
    io.ext_in_valid = '0; io.ext_in_data = '0; io.ext_out_ready = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #3;
    check("rst_in_ready", io.ext_in_ready, {NCHAN{1'b1}});
    check("rst_out_valid", io.ext_out_valid, 0);
    check("rst_rsp_valid", io.rsp_valid, 0);
    check("rst_err", io.err, 0);
    reset = 1'b0;

    // FIFO order on input channel 0
    ext_push(0, 33); ext_push(0, 22); ext_push(0, 11);
    do_cmd(IO_INSIZE, 0, 0, 1, 3, "insize3");
    do_cmd(IO_IN, 0, 0, 1, 33, "in_33");
    do_cmd(IO_IN, 0, 0, 1, 22, "in_22");
    do_cmd(IO_IN, 0, 0, 1, 11, "in_11");
    do_cmd(IO_INSIZE, 0, 0, 1, 0, "insize0");

    // blocking read on empty channel 1, no bypass of the arriving push
    @(negedge clock);
    io.cmd_valid = 1; io.cmd_op = IO_IN; io.cmd_chan = CW'(1);
    io.ext_in_valid[1] = 1; io.ext_in_data[1*WIDTH +: WIDTH] = 7;
    #1; check("in1_stall", io.cmd_ready, 0);
    @(negedge clock);
    io.ext_in_valid[1] = 0;
    #1; check("in1_ready", io.cmd_ready, 1);
    @(negedge clock);
    io.cmd_valid = 0;
    #3; check("in1_rsp_valid", io.rsp_valid, 1); check("in1_rsp", io.rsp_data, 7);

    // output channel 0 fills, stalls, then drains in order
    for (int i = 1; i <= 3; i++) do_cmd(IO_OUT, 0, WIDTH'(i), 0, 0, "out");
    do_cmd(IO_OUTFREE, 0, 0, 1, 5, "outfree5");
    for (int i = 4; i <= 8; i++) do_cmd(IO_OUT, 0, WIDTH'(i), 0, 0, "out");
    @(negedge clock);
    io.cmd_valid = 1; io.cmd_op = IO_OUT; io.cmd_chan = CW'(0); io.cmd_data = 9;
    #1; check("out_full_stall", io.cmd_ready, 0);
    @(negedge clock);
    io.cmd_valid = 0; io.ext_out_ready[0] = 1;
    #1;
    k = 1;
    for (int i = 0; i < 12; i++) begin
      if (io.ext_out_valid[0]) begin
        check("drain_order", io.ext_out_data[0 +: WIDTH], k);
        k++;
      end
      @(negedge clock); #1;
    end
    check("drain_count", k, 9);
    io.ext_out_ready[0] = 0;

    // full input channel: push waits one cycle behind the machine pop
    for (int i = 0; i < DEPTH; i++) ext_push(0, WIDTH'(100 + i));
    #1; check("in0_full", io.ext_in_ready[0], 0);
    @(negedge clock);
    io.cmd_valid = 1; io.cmd_op = IO_IN; io.cmd_chan = CW'(0);
    io.ext_in_valid[0] = 1; io.ext_in_data[0 +: WIDTH] = 200;
    #1; check("full_push_wait", io.ext_in_ready[0], 0);
    @(negedge clock);
    io.cmd_valid = 0;
    #1; check("push_after_pop", io.ext_in_ready[0], 1);
    #2; check("full_rsp", io.rsp_data, 100);
    @(negedge clock);
    io.ext_in_valid[0] = 0;
    exp_seq.delete();
    for (int i = 101; i <= 107; i++) exp_seq.push_back(WIDTH'(i));
    exp_seq.push_back(200);

    // concurrent push/pop through wrap-around
    nv = 300; prev_acc = 0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clock);
      io.cmd_valid = (i < 20); io.cmd_op = IO_IN; io.cmd_chan = CW'(0);
      io.ext_in_valid[0] = (i < 20); io.ext_in_data[0 +: WIDTH] = nv;
      #1;
      push_now = io.ext_in_ready[0] && io.ext_in_valid[0];
      acc_now  = io.cmd_ready && io.cmd_valid;
      #2;
      if (prev_acc) begin
        check("wrap_valid", io.rsp_valid, 1);
        check("wrap_order", io.rsp_data, exp_seq.pop_front());
      end
      if (push_now) begin exp_seq.push_back(nv); nv++; end
      prev_acc = acc_now;
    end
    io.ext_in_valid = '0;

    // bad channel
    do_cmd(IO_OUT, 3, 5, 1, 0, "bad_rsp");
    check("bad_err", io.err, 1);
    check("bad_no_out", io.ext_out_valid, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      io.cmd_valid = $urandom_range(0, 1);
      io.cmd_op    = io_op_t'($urandom_range(0, 3));
      io.cmd_chan  = CW'($urandom_range(0, 3));
      io.cmd_data  = WIDTH'($urandom);
      for (int c = 0; c < NCHAN; c++) begin
        io.ext_in_valid[c]  = ($urandom_range(0, 3) != 0);
        io.ext_out_ready[c] = ($urandom_range(0, 2) == 0);
        io.ext_in_data[c*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
    end
    @(negedge clock);
    io.cmd_valid = 0; io.ext_in_valid = '0; io.ext_out_ready = '0;

    // reset with data stored and a response in flight
    @(negedge clock); reset = 1;
    @(negedge clock); reset = 0;
    for (int i = 0; i < 4; i++) ext_push(0, WIDTH'(40 + i));
    do_cmd(IO_OUT, 1, 9, 0, 0, "out1");
    do_cmd(IO_INSIZE, 0, 0, 1, 4, "insize4");
    @(negedge clock);
    io.cmd_valid = 1; io.cmd_op = IO_IN; io.cmd_chan = CW'(0);
    @(negedge clock);
    io.cmd_valid = 0; reset = 1;
    #3; check("due_rsp", io.rsp_data, 40);
    @(negedge clock);
    reset = 0;
    #3;
    check("post_rst_rsp_valid", io.rsp_valid, 0);
    check("post_rst_out_valid", io.ext_out_valid, 0);
    check("post_rst_in_ready", io.ext_in_ready, {NCHAN{1'b1}});
    do_cmd(IO_INSIZE, 0, 0, 1, 0, "post_rst_insize");

    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
